// File: rtl/morse_symbol_collector.sv
// -----------------------------------------------------------------------------
// morse_symbol_collector
//
// Timing front-end of the Morse receive path. Measures key-down (mark) and
// key-up (gap) durations in units of an external timebase tick. Each mark is
// classified as a dit or a dah and shifted into a pattern register. A letter
// gap publishes {len, dits_dahs} with a one-cycle char_valid pulse. A word gap
// publishes a one-cycle word_valid pulse.
//
// Optional feature macro: MORSE_GLITCH_FILTER_EN
//   When defined, a mark shorter than GLITCH_TICKS is discarded. The FSM then
//   resumes the state it left, and the gap count continues from where it was.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   tick        in   timebase enable, one clk wide
//   key         in   synchronised, debounced key (1 = pressed)
//   len         out  symbol count of last completed letter (0 = invalid)
//   dits_dahs   out  last completed pattern, dit=1 dah=0, newest in bit 0
//   char_valid  out  one-clk pulse: len/dits_dahs hold a new letter
//   word_valid  out  one-clk pulse: word gap detected
//   overflow    out  one-clk pulse with char_valid when the letter was too long
//   busy        out  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------

`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 5
`endif
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 3
`endif

module morse_symbol_collector #(
  parameter int DAH_MIN_TICKS    = 2,
  parameter int LETTER_GAP_TICKS = 3,
  parameter int WORD_GAP_TICKS   = 7,
  parameter int CNT_W            = 8,
  parameter int GLITCH_TICKS     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      key,
  output logic [`MORSE_LEN_W-1:0]   len,
  output logic [`MAX_MORSE_LEN-1:0] dits_dahs,
  output logic                      char_valid,
  output logic                      word_valid,
  output logic                      overflow,
  output logic                      busy
);

  localparam int MAX_LEN = `MAX_MORSE_LEN;
  localparam int LEN_W   = `MORSE_LEN_W;

  localparam logic [CNT_W-1:0] DAH_MIN    = CNT_W'(DAH_MIN_TICKS);
  localparam logic [CNT_W-1:0] LETTER_GAP = CNT_W'(LETTER_GAP_TICKS);
  localparam logic [CNT_W-1:0] WORD_GAP   = CNT_W'(WORD_GAP_TICKS);
  localparam logic [CNT_W-1:0] GLITCH_MIN = CNT_W'(GLITCH_TICKS);
  localparam logic [LEN_W-1:0] MAX_CNT    = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MARK      = 2'd1,
    GAP       = 2'd2,
    WORD_WAIT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MAX_LEN-1:0]   sh_q, sh_d;
  logic [LEN_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [MAX_LEN-1:0]   dd_q, dd_d;
  logic                 char_valid_q, char_valid_d;
  logic                 word_valid_q, word_valid_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 glitch;

  // Saturating increment: a very long mark must not wrap back into dit range.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign cnt_inc = sat_inc(cnt_q);

`ifdef MORSE_GLITCH_FILTER_EN
  // Where a mark came from and the gap count at that moment, so that a glitch
  // can be undone as if it had never happened.
  state_t           ret_state_q, ret_state_d;
  logic [CNT_W-1:0] saved_cnt_q, saved_cnt_d;

  assign glitch = (cnt_q < GLITCH_MIN);
`else
  logic unused_glitch_min;

  assign unused_glitch_min = ^GLITCH_MIN;
  assign glitch            = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    len_d        = len_q;
    dd_d         = dd_q;
    char_valid_d = 1'b0;
    word_valid_d = 1'b0;
    overflow_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key) begin
          state_d = MARK;
          cnt_d   = '0;
        end
      end

      MARK: begin
        // The release edge wins over a tick in the same clk: classify on the
        // count accumulated so far.
        if (!key) begin
          if (glitch) begin
`ifdef MORSE_GLITCH_FILTER_EN
            state_d = ret_state_q;
            cnt_d   = saved_cnt_q;
`endif
          end else begin
            if (count_q == MAX_CNT) begin
              // Letter too long: freeze the pattern and flag it.
              ovf_d = 1'b1;
            end else begin
              sh_d    = {sh_q[MAX_LEN-2:0], (cnt_q < DAH_MIN)};
              count_d = count_q + 1'b1;
            end
            state_d = GAP;
            cnt_d   = '0;
          end
        end else if (tick) begin
          cnt_d = cnt_inc;
        end
      end

      GAP: begin
        if (key) begin
          state_d = MARK;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LETTER_GAP) begin
            if (ovf_q) begin
              len_d      = '0;
              dd_d       = '0;
              overflow_d = 1'b1;
            end else begin
              len_d = count_q;
              dd_d  = sh_q;
            end
            char_valid_d = 1'b1;
            sh_d         = '0;
            count_d      = '0;
            ovf_d        = 1'b0;
            state_d      = WORD_WAIT;
          end
        end
      end

      WORD_WAIT: begin
        // The gap count carries on from the letter gap, so WORD_GAP is
        // measured from the end of the last mark.
        if (key) begin
          state_d = MARK;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == WORD_GAP) begin
            word_valid_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef MORSE_GLITCH_FILTER_EN
  always_comb begin
    ret_state_d = ret_state_q;
    saved_cnt_d = saved_cnt_q;
    if ((state_q != MARK) && (state_d == MARK)) begin
      ret_state_d = state_q;
      saved_cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_state_q <= IDLE;
      saved_cnt_q <= '0;
    end else begin
      ret_state_q <= ret_state_d;
      saved_cnt_q <= saved_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      len_q        <= '0;
      dd_q         <= '0;
      char_valid_q <= 1'b0;
      word_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      len_q        <= len_d;
      dd_q         <= dd_d;
      char_valid_q <= char_valid_d;
      word_valid_q <= word_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign len        = len_q;
  assign dits_dahs  = dd_q;
  assign char_valid = char_valid_q;
  assign word_valid = word_valid_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_morse_symbol_collector.sv
// -----------------------------------------------------------------------------
// Directed testbench for morse_symbol_collector (default parameters).
// Ticks arrive every 4 clk. Inputs change on the falling edge. Outputs are
// observed 1 time unit after the rising edge.
// -----------------------------------------------------------------------------

`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 5
`endif
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 3
`endif

module tb_morse_symbol_collector;

  logic                      clk;
  logic                      rst_n;
  logic                      tick;
  logic                      key;
  logic [`MORSE_LEN_W-1:0]   len;
  logic [`MAX_MORSE_LEN-1:0] dits_dahs;
  logic                      char_valid;
  logic                      word_valid;
  logic                      overflow;
  logic                      busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse monitor state, written only by the monitor process.
  int                        n_char     = 0;
  int                        n_word     = 0;
  int                        n_ovf      = 0;
  int                        n_ovf_char = 0;
  logic [`MORSE_LEN_W-1:0]   last_len   = '0;
  logic [`MAX_MORSE_LEN-1:0] last_dd    = '0;

  morse_symbol_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .key        (key),
    .len        (len),
    .dits_dahs  (dits_dahs),
    .char_valid (char_valid),
    .word_valid (word_valid),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    if (char_valid) begin
      n_char   = n_char + 1;
      last_len = len;
      last_dd  = dits_dahs;
      if (overflow) n_ovf_char = n_ovf_char + 1;
    end
    if (overflow)   n_ovf  = n_ovf + 1;
    if (word_valid) n_word = n_word + 1;
  end

  // n timebase ticks: three quiet clocks, then one clock with tick high.
  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b0;
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic mark(input int n);
    key = 1'b1;
    ticks(n);
    key = 1'b0;
  endtask

  task automatic flush();
    key = 1'b0;
    ticks(8);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key   = 1'b0;
    tick  = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({len, dits_dahs, char_valid, word_valid, overflow, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got len=%0d dd=%b cv=%b wv=%b ovf=%b busy=%b, expected all 0",
               len, dits_dahs, char_valid, word_valid, overflow, busy);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single_dit();
    int c0;
    logic busy_seen;
    c0  = n_char;
    key = 1'b1;
    @(negedge clk);
    busy_seen = busy;
    ticks(1);
    key = 1'b0;
    ticks(3);
    n_checks++;
    if (busy_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL dit_busy: busy=%b expected 1", busy_seen);
    end
    n_checks++;
    if (n_char - c0 !== 1) begin
      n_fail++;
      $display("FAIL dit_char_count: got %0d expected 1", n_char - c0);
    end
    n_checks++;
    if (last_len !== 3'd1 || last_dd !== 5'b00001) begin
      n_fail++;
      $display("FAIL dit_pattern: len=%0d dd=%b expected len=1 dd=00001", last_len, last_dd);
    end
    flush();
  endtask

  task automatic test_dit_dah();
    int c0;
    int o0;
    c0 = n_char;
    o0 = n_ovf;
    mark(1);
    ticks(1);
    mark(3);
    ticks(3);
    n_checks++;
    if (n_char - c0 !== 1) begin
      n_fail++;
      $display("FAIL ditdah_char_count: got %0d expected 1", n_char - c0);
    end
    n_checks++;
    if (last_len !== 3'd2 || last_dd !== 5'b00010) begin
      n_fail++;
      $display("FAIL ditdah_pattern: len=%0d dd=%b expected len=2 dd=00010", last_len, last_dd);
    end
    n_checks++;
    if (n_ovf - o0 !== 0) begin
      n_fail++;
      $display("FAIL ditdah_overflow: got %0d pulses expected 0", n_ovf - o0);
    end
    flush();
  endtask

  task automatic test_word_gap();
    int c0;
    int w0;
    c0 = n_char;
    w0 = n_word;
    mark(3);
    ticks(1);
    mark(1);
    ticks(1);
    mark(1);
    ticks(3);
    n_checks++;
    if (n_char - c0 !== 1 || last_len !== 3'd3 || last_dd !== 5'b00011) begin
      n_fail++;
      $display("FAIL word_char: count=%0d len=%0d dd=%b expected count=1 len=3 dd=00011",
               n_char - c0, last_len, last_dd);
    end
    ticks(3);
    n_checks++;
    if (n_word - w0 !== 0) begin
      n_fail++;
      $display("FAIL word_early: got %0d pulses after 6 gap ticks expected 0", n_word - w0);
    end
    ticks(1);
    n_checks++;
    if (n_word - w0 !== 1) begin
      n_fail++;
      $display("FAIL word_pulse: got %0d pulses after 7 gap ticks expected 1", n_word - w0);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL word_busy: busy=%b expected 0", busy);
    end
    ticks(6);
    n_checks++;
    if (n_word - w0 !== 1 || n_char - c0 !== 1) begin
      n_fail++;
      $display("FAIL word_once: words=%0d chars=%0d expected 1 and 1", n_word - w0, n_char - c0);
    end
  endtask

  task automatic test_overflow();
    int c0;
    int o0;
    int oc0;
    c0  = n_char;
    o0  = n_ovf;
    oc0 = n_ovf_char;
    for (int i = 0; i < 6; i++) begin
      mark(1);
      if (i < 5) ticks(1);
    end
    ticks(3);
    n_checks++;
    if (n_char - c0 !== 1 || n_ovf - o0 !== 1 || n_ovf_char - oc0 !== 1) begin
      n_fail++;
      $display("FAIL ovf_pulses: chars=%0d ovf=%0d ovf_with_char=%0d expected 1 1 1",
               n_char - c0, n_ovf - o0, n_ovf_char - oc0);
    end
    n_checks++;
    if (last_len !== 3'd0 || last_dd !== 5'b00000) begin
      n_fail++;
      $display("FAIL ovf_pattern: len=%0d dd=%b expected len=0 dd=00000", last_len, last_dd);
    end
    mark(1);
    ticks(3);
    n_checks++;
    if (n_char - c0 !== 2 || last_len !== 3'd1 || last_dd !== 5'b00001 || n_ovf - o0 !== 1) begin
      n_fail++;
      $display("FAIL ovf_recover: chars=%0d len=%0d dd=%b ovf=%0d expected 2 1 00001 1",
               n_char - c0, last_len, last_dd, n_ovf - o0);
    end
    flush();
  endtask

  task automatic test_key_priority();
    int c0;
    int w0;
    c0 = n_char;
    w0 = n_word;
    mark(1);
    ticks(2);
    // Third gap tick arrives in the same clk as the key press.
    repeat (3) @(negedge clk);
    tick = 1'b1;
    key  = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n_checks++;
    if (n_char - c0 !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_gap_tick: chars=%0d busy=%b expected 0 and 1", n_char - c0, busy);
    end
    ticks(1);
    key = 1'b0;
    ticks(3);
    n_checks++;
    if (n_char - c0 !== 1 || last_len !== 3'd2 || last_dd !== 5'b00011) begin
      n_fail++;
      $display("FAIL prio_letter: count=%0d len=%0d dd=%b expected 1 2 00011",
               n_char - c0, last_len, last_dd);
    end
    // Gap count is 5 here; a new mark must cancel the pending word break.
    ticks(2);
    mark(1);
    n_checks++;
    if (n_word - w0 !== 0) begin
      n_fail++;
      $display("FAIL prio_word_cancel: got %0d word pulses expected 0", n_word - w0);
    end
    ticks(3);
    n_checks++;
    if (n_char - c0 !== 2 || last_len !== 3'd1 || last_dd !== 5'b00001) begin
      n_fail++;
      $display("FAIL prio_next_letter: count=%0d len=%0d dd=%b expected 2 1 00001",
               n_char - c0, last_len, last_dd);
    end
    ticks(4);
    n_checks++;
    if (n_word - w0 !== 1) begin
      n_fail++;
      $display("FAIL prio_word_final: got %0d word pulses expected 1", n_word - w0);
    end
    flush();
  endtask

  task automatic test_saturation();
    int c0;
    c0 = n_char;
    mark(257);
    ticks(3);
    n_checks++;
    if (n_char - c0 !== 1 || last_len !== 3'd1 || last_dd !== 5'b00000) begin
      n_fail++;
      $display("FAIL sat_dah: count=%0d len=%0d dd=%b expected 1 1 00000",
               n_char - c0, last_len, last_dd);
    end
    flush();
    // Leave a non-zero pattern registered so the reset test sees it cleared.
    mark(1);
    ticks(3);
    flush();
  endtask

  task automatic test_reset_mid_mark();
    int c0;
    key = 1'b1;
    ticks(2);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({len, dits_dahs, char_valid, word_valid, overflow, busy} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: len=%0d dd=%b cv=%b wv=%b ovf=%b busy=%b expected all 0",
               len, dits_dahs, char_valid, word_valid, overflow, busy);
    end
    @(negedge clk);
    key   = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    c0 = n_char;
    mark(1);
    ticks(3);
    n_checks++;
    if (n_char - c0 !== 1 || last_len !== 3'd1 || last_dd !== 5'b00001) begin
      n_fail++;
      $display("FAIL midreset_fresh: count=%0d len=%0d dd=%b expected 1 1 00001",
               n_char - c0, last_len, last_dd);
    end
    flush();
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 1'b0;
    tick  = 1'b0;
    test_reset();
    test_single_dit();
    test_dit_dah();
    test_word_gap();
    test_overflow();
    test_key_priority();
    test_saturation();
    test_reset_mid_mark();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_symbol_collector.md
Name: morse_symbol_collector

Overview:
Timing front-end of the Morse receive path. It measures key-down and key-up durations on a debounced key in units of an external timebase tick. It classifies each mark as dit or dah and shifts the symbols into a pattern register. At a letter gap it presents {len, dits_dahs} with a one-cycle valid pulse to the combinational character recogniser; at a word gap it emits a word-break pulse.

Parameters:
DAH_MIN_TICKS, 2, marks lasting >= this many ticks are dahs; shorter marks are dits
LETTER_GAP_TICKS, 3, key-up duration (ticks) that ends a letter
WORD_GAP_TICKS, 7, key-up duration (ticks, counted from the end of the last mark) that ends a word; must be > LETTER_GAP_TICKS
CNT_W, 8, tick counter width; counter saturates at 2^CNT_W-1
GLITCH_TICKS, 1, minimum mark length; used only with the optional feature

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  timebase enable, one clk wide
key  in  1  synchronised, debounced key; 1 = pressed
len  out  `MORSE_LEN_W  symbol count of the last completed letter (0 = invalid)
dits_dahs  out  `MAX_MORSE_LEN  last completed pattern; dit=1, dah=0; newest symbol in bit 0; unused upper bits 0
char_valid  out  1  one-clk pulse: len/dits_dahs hold a new letter
word_valid  out  1  one-clk pulse: word gap detected
overflow  out  1  one-clk pulse coincident with char_valid when the letter exceeded `MAX_MORSE_LEN symbols
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; counter, shift register, symbol count, len, dits_dahs = 0; all pulses 0; busy 0.
- All state, count and output updates occur on the rising edge of clk.
- States: IDLE, MARK, GAP, WORD_WAIT.
- IDLE: key=1 -> MARK, cnt=0.
- MARK: on tick, cnt+1 (saturating). On key=0, classify the symbol: dah if cnt >= DAH_MIN_TICKS, else dit. Shift it in: sh <= {sh[MAX-2:0], sym}; count+1; ovf_flag set if count is already `MAX_MORSE_LEN (sh and count then frozen). -> GAP, cnt=0.
- GAP: key=1 -> MARK, cnt=0. Otherwise, on tick, cnt+1. When cnt reaches LETTER_GAP_TICKS:
  - Register the outputs: len=count, dits_dahs=sh. If ovf_flag, instead len=0, dits_dahs=0 and pulse overflow.
  - Pulse char_valid.
  - Clear sh, count and ovf_flag; -> WORD_WAIT. cnt keeps counting.
- WORD_WAIT: key=1 -> MARK, cnt=0, with no word_valid. On tick, cnt+1; when cnt reaches WORD_GAP_TICKS, pulse word_valid -> IDLE.
- Priority: a key edge beats a tick in the same clk; that tick is not counted.
- Latency: char_valid asserts on the clk edge at which the LETTER_GAP_TICKS-th gap tick is sampled; outputs are registered, not combinational.
- len/dits_dahs hold their value between char_valid pulses.
- word_valid fires at most once per gap and never without a preceding char_valid.
- A saturated mark counter is still a dah.

Optional Feature:
MORSE_GLITCH_FILTER_EN:
- Defined: in MARK, a key release with cnt < GLITCH_TICKS discards the mark. Nothing is shifted, count is unchanged, and the FSM returns to the state it left with cnt restored: IDLE, GAP, or WORD_WAIT (the gap count resumes from its prior value). Requires a saved-counter register.
- Undefined: every mark is classified, including 0-tick marks (dit). GLITCH_TICKS is ignored.

Test Plan:
- Defaults, tick every 4 clk. Key high 1 tick, low 3 ticks -> one char_valid, len=1, dits_dahs=5'b00001; busy high during the sequence.
- dit (1 tick), 1-tick gap, dah (3 ticks), 3-tick gap -> len=2, dits_dahs=5'b00010; no overflow.
- dah, dit, dit with 1-tick gaps, then 7-tick gap -> char_valid with len=3, dits_dahs=5'b00011; word_valid exactly once, 4 ticks later; busy drops to 0.
- Six dits, then 3-tick gap -> char_valid with overflow=1, len=0, dits_dahs=0. The next letter (one dit) yields len=1, 5'b00001.
- Key rises in the same clk as a tick in GAP -> tick ignored, MARK entered, no char_valid. Key rises in WORD_WAIT at gap tick 5 -> no word_valid.
- rst_n low mid-MARK after 2 ticks -> all outputs 0, state IDLE immediately. After release, a fresh 1-tick mark decodes as len=1 dit.
